// File: rtl/sftm_pipelined_core.sv
// rtl/sftm_pipelined_core.sv - tagged job FIFO feeding an overlapped PreTU / SCU / PostTU pipeline
module sftm_pipelined_core #(
    parameter int POF                  = 4,
    parameter int PIF                  = 12,
    parameter int SCU_MULTIPLIERS      = 18,
    parameter int PRETU_LATENCY        = 4,
    parameter int POSTTU_LATENCY       = 4,
    parameter int SCU_PIPELINE_LATENCY = 2,
    parameter int MULT_WIDTH           = 32,
    parameter int FIFO_DEPTH           = 8,
    parameter int ID_WIDTH             = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            job_valid,
    output logic                            job_ready,
    input  logic [POF*PIF*MULT_WIDTH-1:0]   job_mults_flat,
    input  logic [ID_WIDTH-1:0]             job_id,
    input  logic                            hold,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            done_valid,
    output logic [ID_WIDTH-1:0]             done_id,
    output logic [MULT_WIDTH:0]             done_cycles
);
    localparam int NCH = POF * PIF;
    localparam int FW  = NCH * MULT_WIDTH;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int SW  = MULT_WIDTH + 1;

    logic [FW-1:0]       mem_mults_q [FIFO_DEPTH];
    logic [ID_WIDTH-1:0] mem_id_q    [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic                full, empty, push, pop;

    logic                pre_v_q, pre_v_d, scu_v_q, scu_v_d, post_v_q, post_v_d;
    logic [ID_WIDTH-1:0] pre_id_q, pre_id_d, scu_id_q, scu_id_d, post_id_q, post_id_d;
    logic [SW-1:0]       pre_s_q, pre_s_d, scu_s_q, scu_s_d, post_s_q, post_s_d;
    logic [SW-1:0]       pre_cnt_q, pre_cnt_d, scu_cnt_q, scu_cnt_d, post_cnt_q, post_cnt_d;
    logic                pre_fin, scu_fin, post_fin, pre_free, scu_free, post_free;

    logic                done_valid_q;
    logic [ID_WIDTH-1:0] done_id_q;
    logic [SW-1:0]       done_cycles_q;

    logic [FW-1:0]       head_mults;
    logic [SW-1:0]       m_ext, ch, s_max, s_calc;

    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign job_ready  = !full && !rst;
    assign push       = job_valid && job_ready;
    assign fifo_count = count_q;
    assign head_mults = mem_mults_q[rd_ptr_q];

    // Stage-free chain resolves from the tail so a whole train can advance on one edge.
    assign post_fin  = post_v_q && (post_cnt_q == '0);
    assign scu_fin   = scu_v_q && (scu_cnt_q == '0);
    assign pre_fin   = pre_v_q && (pre_cnt_q == '0);
    assign post_free = !post_v_q || post_fin;
    assign scu_free  = !scu_v_q || (scu_fin && post_free);
    assign pre_free  = !pre_v_q || (pre_fin && scu_free);
    assign pop       = pre_free && !empty && !hold;

    assign busy        = !empty || pre_v_q || scu_v_q || post_v_q;
    assign done_valid  = done_valid_q;
    assign done_id     = done_id_q;
    assign done_cycles = done_cycles_q;

    // SCU occupancy is the slowest channel's ceil(m / multipliers) plus fixed overhead.
    always_comb begin
        s_max = '0;
        m_ext = '0;
        ch    = '0;
        for (int i = 0; i < NCH; i++) begin
            m_ext = SW'(head_mults[i*MULT_WIDTH +: MULT_WIDTH]);
            ch    = (m_ext + SW'(SCU_MULTIPLIERS - 1)) / SW'(SCU_MULTIPLIERS);
            if (ch > s_max) s_max = ch;
        end
        s_calc = s_max + SW'(SCU_PIPELINE_LATENCY);
    end

    always_comb begin
        pre_v_d    = pre_v_q;
        pre_id_d   = pre_id_q;
        pre_s_d    = pre_s_q;
        pre_cnt_d  = pre_cnt_q;
        scu_v_d    = scu_v_q;
        scu_id_d   = scu_id_q;
        scu_s_d    = scu_s_q;
        scu_cnt_d  = scu_cnt_q;
        post_v_d   = post_v_q;
        post_id_d  = post_id_q;
        post_s_d   = post_s_q;
        post_cnt_d = post_cnt_q;

        if (pop) begin
            pre_v_d   = 1'b1;
            pre_id_d  = mem_id_q[rd_ptr_q];
            pre_s_d   = s_calc;
            pre_cnt_d = SW'(PRETU_LATENCY - 1);
        end else if (pre_fin && scu_free) begin
            pre_v_d = 1'b0;
        end else if (pre_v_q && !pre_fin) begin
            pre_cnt_d = pre_cnt_q - 1'b1;
        end

        if (pre_fin && scu_free) begin
            scu_v_d   = 1'b1;
            scu_id_d  = pre_id_q;
            scu_s_d   = pre_s_q;
            scu_cnt_d = pre_s_q - 1'b1;
        end else if (scu_fin && post_free) begin
            scu_v_d = 1'b0;
        end else if (scu_v_q && !scu_fin) begin
            scu_cnt_d = scu_cnt_q - 1'b1;
        end

        if (scu_fin && post_free) begin
            post_v_d   = 1'b1;
            post_id_d  = scu_id_q;
            post_s_d   = scu_s_q;
            post_cnt_d = SW'(POSTTU_LATENCY - 1);
        end else if (post_fin) begin
            post_v_d = 1'b0;
        end else if (post_v_q) begin
            post_cnt_d = post_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_mults_q[wr_ptr_q] <= job_mults_flat;
            mem_id_q[wr_ptr_q]    <= job_id;
        end
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_v_q       <= 1'b0;
            scu_v_q       <= 1'b0;
            post_v_q      <= 1'b0;
            pre_id_q      <= '0;
            scu_id_q      <= '0;
            post_id_q     <= '0;
            pre_s_q       <= '0;
            scu_s_q       <= '0;
            post_s_q      <= '0;
            pre_cnt_q     <= '0;
            scu_cnt_q     <= '0;
            post_cnt_q    <= '0;
            done_valid_q  <= 1'b0;
            done_id_q     <= '0;
            done_cycles_q <= '0;
        end else begin
            pre_v_q       <= pre_v_d;
            scu_v_q       <= scu_v_d;
            post_v_q      <= post_v_d;
            pre_id_q      <= pre_id_d;
            scu_id_q      <= scu_id_d;
            post_id_q     <= post_id_d;
            pre_s_q       <= pre_s_d;
            scu_s_q       <= scu_s_d;
            post_s_q      <= post_s_d;
            pre_cnt_q     <= pre_cnt_d;
            scu_cnt_q     <= scu_cnt_d;
            post_cnt_q    <= post_cnt_d;
            done_valid_q  <= post_fin;
            if (post_fin) begin
                done_id_q     <= post_id_q;
                done_cycles_q <= post_s_q;
            end
        end
    end
endmodule

// File: tb/tb_sftm_pipelined_core.sv
// tb/tb_sftm_pipelined_core.sv - scoreboard bench for sftm_pipelined_core
module tb_sftm_pipelined_core;
    localparam int FW = 4 * 12 * 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [FW-1:0] job_mults_flat = '0;
    logic [7:0]    job_id = '0;
    logic          hold = 1'b0;
    logic          busy;
    logic [3:0]    fifo_count;
    logic          done_valid;
    logic [7:0]    done_id;
    logic [32:0]   done_cycles;

    typedef struct {
        logic [7:0] id;
        longint     cycles;
        longint     at;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    int     tests = 0;
    int     fails = 0;

    sftm_pipelined_core dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_mults_flat(job_mults_flat), .job_id(job_id), .hold(hold),
        .busy(busy), .fifo_count(fifo_count), .done_valid(done_valid),
        .done_id(done_id), .done_cycles(done_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [FW-1:0] all_m(input logic [31:0] v);
        logic [FW-1:0] r;
        for (int i = 0; i < 48; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    // Monitor: every completion pulse must match the oldest expected job.
    always @(negedge clk) begin
        if (done_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_id", done_id, e.id);
                check("done_cycles", done_cycles, e.cycles);
                check("done_cycle_no", cyc, e.at);
            end
        end
    end

    task automatic push_job(input logic [7:0] id, input logic [FW-1:0] m,
                            input longint cycles, input longint delay, input bit track);
        @(negedge clk);
        job_valid      = 1'b1;
        job_id         = id;
        job_mults_flat = m;
        check("job_ready_on_push", job_ready, 1);
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        if (track) sb.push_back('{id, cycles, cyc + delay});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [FW-1:0] m;
        longint r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_job_ready", job_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_id", done_id, 0);
        check("rst_done_cycles", done_cycles, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_job_ready", job_ready, 1);

        push_job(8'h11, all_m(36), 4, 13, 1'b1);
        drain();

        m = '0;
        m[5*32 +: 32] = 32'd37;
        push_job(8'h21, m, 5, 14, 1'b1);
        drain();
        push_job(8'h22, all_m(0), 2, 11, 1'b1);
        drain();

        push_job(8'h01, all_m(36), 4, 13, 1'b1);
        push_job(8'h02, all_m(36), 4, 16, 1'b1);
        push_job(8'h03, all_m(36), 4, 19, 1'b1);
        drain();

        push_job(8'hA0, all_m(180), 12, 21, 1'b1);
        push_job(8'hB0, all_m(36), 4, 24, 1'b1);
        drain();

        hold = 1'b1;
        for (int k = 1; k <= 8; k++) push_job(8'(k), all_m(36), 4, 0, 1'b0);
        @(negedge clk);
        check("hold_fifo_full", fifo_count, 8);
        check("hold_ready_low", job_ready, 0);
        check("hold_busy", busy, 1);
        job_valid = 1'b1;
        job_id    = 8'h09;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        @(negedge clk);
        check("full_push_ignored", fifo_count, 8);
        hold = 1'b0;
        r = cyc + 1;
        for (int k = 0; k < 8; k++) sb.push_back('{8'(k + 1), 4, r + 12 + 4 * k});
        drain();

        for (int k = 0; k < 5; k++) push_job(8'(8'h40 + k), all_m(36), 4, 0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_fifo_count", fifo_count, 3);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_fifo_count", fifo_count, 0);
        check("post_rst_ready", job_ready, 0);
        check("post_rst_done_valid", done_valid, 0);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        push_job(8'h77, all_m(36), 4, 13, 1'b1);
        drain();

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
